// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default widths, ALU control codes,
// ALUOp and funct3 encodings, and the EX-stage control bundle.
package riscv_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

  // Shift ops take only the low five bits of the B operand as the shift amount
  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs of the
// ID/EX stage. master = surrounding pipeline, slave = the stage itself.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_alu_src;
  logic [1:0]        id_alu_op;
  logic [2:0]        id_funct3;
  logic              id_funct7_5;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_branch;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [XLEN-1:0]   exmem_rslt;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_reg_write;
  logic [XLEN-1:0]   memwb_data;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_branch;
  logic              load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3,
           id_funct7_5, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, exmem_rd, exmem_reg_write, exmem_rslt,
           memwb_rd, memwb_reg_write, memwb_data,
    input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
           load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_src, id_alu_op, id_funct3,
           id_funct7_5, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, exmem_rd, exmem_reg_write, exmem_rslt,
           memwb_rd, memwb_reg_write, memwb_data,
    output alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_valid,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
           load_use_hazard
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: ALUOp + funct3 + funct7[5] -> 4-bit code.
module alu_ctrl_dec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] ctrl_o
);

  // Decode; SRA and unlisted funct3 values fall to NOP, for which the ALU yields 0
  always_comb begin
    ctrl_o = ALU_NOP;
    case (alu_op_i)
      ALUOP_ADD: ctrl_o = ALU_ADD;
      ALUOP_SUB: ctrl_o = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3_i)
          F3_ADD_SUB: ctrl_o = ((alu_op_i == ALUOP_RTYPE) && funct7_5_i) ? ALU_SUB : ALU_ADD;
          F3_AND:     ctrl_o = ALU_AND;
          F3_OR:      ctrl_o = ALU_OR;
          F3_SLL:     ctrl_o = ALU_SLL;
          F3_SRL_SRA: ctrl_o = funct7_5_i ? ALU_NOP : ALU_SRL;
          default:    ctrl_o = ALU_NOP;
        endcase
      end
      default: ctrl_o = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: registers decoded operands and
// control, forwards from EX/MEM and MEM/WB, and inserts load-use bubbles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave pipe
);

  logic              valid_q, valid_d;
  ex_ctrl_t          ctrl_q, ctrl_d, id_ctrl;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              alu_src_q, alu_src_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d, dec_ctrl;
  logic              hazard;
  logic              a_from_exmem, a_from_memwb, b_from_exmem, b_from_memwb;
  logic [XLEN-1:0]   fwd_a, fwd_b, b_raw, b_op;

  alu_ctrl_dec u_dec (
    .alu_op_i   (pipe.id_alu_op),
    .funct3_i   (pipe.id_funct3),
    .funct7_5_i (pipe.id_funct7_5),
    .ctrl_o     (dec_ctrl)
  );

  assign id_ctrl = '{reg_write:  pipe.id_reg_write,
                     mem_read:   pipe.id_mem_read,
                     mem_write:  pipe.id_mem_write,
                     mem_to_reg: pipe.id_mem_to_reg,
                     branch:     pipe.id_branch};

  assign hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                  ((rd_q == pipe.id_rs1) || (rd_q == pipe.id_rs2)) && pipe.id_valid;

  // Next-state: flush beats stall beats hazard bubble beats a normal load; bubbles keep data
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    alu_src_d  = alu_src_q;
    alu_ctrl_d = alu_ctrl_q;
    if (pipe.flush || (!pipe.stall && hazard)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!pipe.stall) begin
      valid_d    = pipe.id_valid;
      ctrl_d     = id_ctrl;
      rd_d       = pipe.id_rd;
      rs1_d      = pipe.id_rs1;
      rs2_d      = pipe.id_rs2;
      rs1_data_d = pipe.id_rs1_data;
      rs2_data_d = pipe.id_rs2_data;
      imm_d      = pipe.id_imm;
      alu_src_d  = pipe.id_alu_src;
      alu_ctrl_d = dec_ctrl;
    end
  end

  // Stage registers; reset leaves an invalid slot with an ADD control code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      alu_ctrl_q <= ALU_ADD;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      alu_src_q  <= alu_src_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign a_from_exmem = pipe.exmem_reg_write && (pipe.exmem_rd != '0) && (pipe.exmem_rd == rs1_q);
  assign a_from_memwb = pipe.memwb_reg_write && (pipe.memwb_rd != '0) && (pipe.memwb_rd == rs1_q);
  assign b_from_exmem = pipe.exmem_reg_write && (pipe.exmem_rd != '0) && (pipe.exmem_rd == rs2_q);
  assign b_from_memwb = pipe.memwb_reg_write && (pipe.memwb_rd != '0) && (pipe.memwb_rd == rs2_q);

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
    if (a_from_exmem)      fwd_a = pipe.exmem_rslt;
    else if (a_from_memwb) fwd_a = pipe.memwb_data;
    if (b_from_exmem)      fwd_b = pipe.exmem_rslt;
    else if (b_from_memwb) fwd_b = pipe.memwb_data;
  end

  // B operand select, trimmed to a 5-bit shift amount for shift ops
  always_comb begin
    b_raw = alu_src_q ? imm_q : fwd_b;
    b_op  = b_raw;
    if (is_shift(alu_ctrl_q)) b_op = {{(XLEN-5){1'b0}}, b_raw[4:0]};
  end

  assign pipe.alu_a           = fwd_a;
  assign pipe.alu_b           = b_op;
  assign pipe.alu_ctrl        = alu_ctrl_q;
  assign pipe.ex_store_data   = fwd_b;
  assign pipe.ex_rd           = rd_q;
  assign pipe.ex_valid        = valid_q;
  assign pipe.ex_reg_write    = valid_q & ctrl_q.reg_write;
  assign pipe.ex_mem_read     = valid_q & ctrl_q.mem_read;
  assign pipe.ex_mem_write    = valid_q & ctrl_q.mem_write;
  assign pipe.ex_mem_to_reg   = valid_q & ctrl_q.mem_to_reg;
  assign pipe.ex_branch       = valid_q & ctrl_q.branch;
  assign pipe.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, decode, forwarding,
// load-use bubbles, stall/flush priority and asynchronous reset.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) pipe ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pipe)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm, input logic src,
    input logic [1:0] op, input logic [2:0] f3, input logic f7,
    input logic rw, input logic mr, input logic mw, input logic m2r, input logic br);
    pipe.id_valid      = v;
    pipe.id_rs1        = rs1;
    pipe.id_rs2        = rs2;
    pipe.id_rd         = rd;
    pipe.id_rs1_data   = d1;
    pipe.id_rs2_data   = d2;
    pipe.id_imm        = imm;
    pipe.id_alu_src    = src;
    pipe.id_alu_op     = op;
    pipe.id_funct3     = f3;
    pipe.id_funct7_5   = f7;
    pipe.id_reg_write  = rw;
    pipe.id_mem_read   = mr;
    pipe.id_mem_write  = mw;
    pipe.id_mem_to_reg = m2r;
    pipe.id_branch     = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random activity on every input
    rst_n = 1'b0;
    pipe.stall = 1'b0;
    pipe.flush = 1'b0;
    applyStimulus(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                  1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    pipe.exmem_rd = 5'($urandom);        pipe.exmem_reg_write = 1'b1; pipe.exmem_rslt = $urandom;
    pipe.memwb_rd = 5'($urandom);        pipe.memwb_reg_write = 1'b1; pipe.memwb_data = $urandom;
    tick();
    tick();
    checkOutput("rst_valid",    32'(pipe.ex_valid),        32'd0);
    checkOutput("rst_rw",       32'(pipe.ex_reg_write),    32'd0);
    checkOutput("rst_mr",       32'(pipe.ex_mem_read),     32'd0);
    checkOutput("rst_mw",       32'(pipe.ex_mem_write),    32'd0);
    checkOutput("rst_m2r",      32'(pipe.ex_mem_to_reg),   32'd0);
    checkOutput("rst_br",       32'(pipe.ex_branch),       32'd0);
    checkOutput("rst_rd",       32'(pipe.ex_rd),           32'd0);
    checkOutput("rst_ctrl",     32'(pipe.alu_ctrl),        32'h2);
    checkOutput("rst_alu_a",    pipe.alu_a,                32'd0);
    checkOutput("rst_hazard",   32'(pipe.load_use_hazard), 32'd0);

    rst_n = 1'b1;
    pipe.exmem_reg_write = 1'b0;
    pipe.memwb_reg_write = 1'b0;

    // R-type SUB: rs1=10, rs2=3
    applyStimulus(1, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 32'd0, 0, 2'b10, 3'b000, 1, 1, 0, 0, 0, 0);
    tick();
    checkOutput("sub_ctrl",  32'(pipe.alu_ctrl),     32'h4);
    checkOutput("sub_a",     pipe.alu_a,             32'd10);
    checkOutput("sub_b",     pipe.alu_b,             32'd3);
    checkOutput("sub_valid", 32'(pipe.ex_valid),     32'd1);
    checkOutput("sub_rd",    32'(pipe.ex_rd),        32'd4);
    checkOutput("sub_rw",    32'(pipe.ex_reg_write), 32'd1);
    checkOutput("sub_st",    pipe.ex_store_data,     32'd3);

    // SLLI with imm 0x25 -> shift amount 5
    applyStimulus(1, 5'd1, 5'd0, 5'd5, 32'd7, 32'd0, 32'h25, 1, 2'b11, 3'b001, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("slli_ctrl", 32'(pipe.alu_ctrl), 32'h9);
    checkOutput("slli_b",    pipe.alu_b,         32'd5);
    checkOutput("slli_a",    pipe.alu_a,         32'd7);

    // Forwarding onto rs1=x5 / rs2=x6 with the stage held by stall
    applyStimulus(1, 5'd5, 5'd6, 5'd9, 32'h1111, 32'h22, 32'd0, 0, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0);
    tick();
    pipe.stall = 1'b1;
    pipe.exmem_rd = 5'd5; pipe.exmem_reg_write = 1'b1; pipe.exmem_rslt = 32'hAAAA;
    pipe.memwb_rd = 5'd5; pipe.memwb_reg_write = 1'b1; pipe.memwb_data = 32'hBBBB;
    #1;
    checkOutput("fwd_exmem_a", pipe.alu_a,             32'hAAAA);
    checkOutput("add_ctrl",    32'(pipe.alu_ctrl),     32'h2);
    pipe.exmem_reg_write = 1'b0;
    #1;
    checkOutput("fwd_memwb_a", pipe.alu_a,             32'hBBBB);
    pipe.exmem_reg_write = 1'b1; pipe.exmem_rd = 5'd6;
    #1;
    checkOutput("fwd_split_a", pipe.alu_a,             32'hBBBB);
    checkOutput("fwd_split_b", pipe.alu_b,             32'hAAAA);
    checkOutput("fwd_store",   pipe.ex_store_data,     32'hAAAA);
    pipe.exmem_rd = 5'd0; pipe.memwb_rd = 5'd0;
    #1;
    checkOutput("fwd_x0_a",    pipe.alu_a,             32'h1111);
    checkOutput("fwd_x0_b",    pipe.alu_b,             32'h22);
    pipe.exmem_reg_write = 1'b0; pipe.memwb_reg_write = 1'b0;

    // Stall for three edges while ID presents a different instruction
    applyStimulus(1, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88, 32'd0, 0, 2'b10, 3'b111, 0, 0, 0, 1, 0, 0);
    tick(); tick(); tick();
    checkOutput("stall_rd",    32'(pipe.ex_rd),        32'd9);
    checkOutput("stall_ctrl",  32'(pipe.alu_ctrl),     32'h2);
    checkOutput("stall_valid", 32'(pipe.ex_valid),     32'd1);
    checkOutput("stall_mw",    32'(pipe.ex_mem_write), 32'd0);
    checkOutput("stall_a",     pipe.alu_a,             32'h1111);
    pipe.stall = 1'b0;

    // Load-use: lw x7 in EX, add reads x7 as rs2
    applyStimulus(1, 5'd2, 5'd0, 5'd7, 32'd100, 32'd0, 32'd8, 1, 2'b00, 3'b010, 0, 1, 1, 0, 1, 0);
    tick();
    checkOutput("lw_mr",  32'(pipe.ex_mem_read), 32'd1);
    checkOutput("lw_b",   pipe.alu_b,            32'd8);
    applyStimulus(1, 5'd3, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 0, 2'b10, 3'b000, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("lu_hazard", 32'(pipe.load_use_hazard), 32'd1);
    tick();
    checkOutput("bub_valid",  32'(pipe.ex_valid),        32'd0);
    checkOutput("bub_rw",     32'(pipe.ex_reg_write),    32'd0);
    checkOutput("bub_mr",     32'(pipe.ex_mem_read),     32'd0);
    checkOutput("bub_m2r",    32'(pipe.ex_mem_to_reg),   32'd0);
    checkOutput("bub_hazard", 32'(pipe.load_use_hazard), 32'd0);
    tick();
    checkOutput("lu_add_valid", 32'(pipe.ex_valid),     32'd1);
    checkOutput("lu_add_rd",    32'(pipe.ex_rd),        32'd8);
    checkOutput("lu_add_ctrl",  32'(pipe.alu_ctrl),     32'h2);
    checkOutput("lu_add_mr",    32'(pipe.ex_mem_read),  32'd0);
    checkOutput("lu_add_b",     pipe.alu_b,             32'd2);

    // Flush beats stall
    pipe.stall = 1'b1; pipe.flush = 1'b1;
    tick();
    checkOutput("sf_valid", 32'(pipe.ex_valid),     32'd0);
    checkOutput("sf_rw",    32'(pipe.ex_reg_write), 32'd0);
    pipe.stall = 1'b0; pipe.flush = 1'b0;

    // Flush during a load-use hazard: one bubble, no later re-issue
    applyStimulus(1, 5'd2, 5'd0, 5'd7, 32'd100, 32'd0, 32'd8, 1, 2'b00, 3'b010, 0, 1, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 5'd7, 5'd1, 5'd8, 32'd1, 32'd2, 32'd0, 0, 2'b10, 3'b000, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("fh_hazard", 32'(pipe.load_use_hazard), 32'd1);
    pipe.flush = 1'b1;
    tick();
    checkOutput("fh_valid", 32'(pipe.ex_valid),     32'd0);
    checkOutput("fh_rw",    32'(pipe.ex_reg_write), 32'd0);
    pipe.flush = 1'b0;
    pipe.id_valid = 1'b0;
    tick();
    checkOutput("fh_no_reissue", 32'(pipe.ex_valid),     32'd0);
    checkOutput("fh_no_rw",      32'(pipe.ex_reg_write), 32'd0);

    // Remaining decode points
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 0, 2'b10, 3'b101, 1, 1, 0, 0, 0, 1);
    tick();
    checkOutput("sra_nop",   32'(pipe.alu_ctrl),  32'hF);
    checkOutput("branch",    32'(pipe.ex_branch), 32'd1);
    applyStimulus(1, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'h3F, 1, 2'b11, 3'b101, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("srli_ctrl", 32'(pipe.alu_ctrl), 32'hA);
    checkOutput("srli_b",    pipe.alu_b,         32'h1F);
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 0, 2'b10, 3'b111, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("and_ctrl",  32'(pipe.alu_ctrl), 32'h0);
    applyStimulus(1, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'h40, 1, 2'b11, 3'b110, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("ori_ctrl",  32'(pipe.alu_ctrl), 32'h1);
    checkOutput("ori_b",     pipe.alu_b,         32'h40);
    applyStimulus(1, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd0, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("beq_ctrl",  32'(pipe.alu_ctrl), 32'h4);
    applyStimulus(1, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'h10, 1, 2'b11, 3'b000, 1, 1, 0, 0, 0, 0);
    tick();
    checkOutput("addi_f7_ctrl", 32'(pipe.alu_ctrl), 32'h2);
    applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 0, 2'b10, 3'b010, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("slt_nop",   32'(pipe.alu_ctrl), 32'hF);

    // Asynchronous reset mid-cycle, then a normal load after release
    applyStimulus(1, 5'd1, 5'd2, 5'd13, 32'd5, 32'd6, 32'd0, 0, 2'b10, 3'b110, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("pre_arst_valid", 32'(pipe.ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(pipe.ex_valid),     32'd0);
    checkOutput("arst_rw",    32'(pipe.ex_reg_write), 32'd0);
    checkOutput("arst_ctrl",  32'(pipe.alu_ctrl),     32'h2);
    checkOutput("arst_rd",    32'(pipe.ex_rd),        32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(pipe.ex_valid), 32'd1);
    checkOutput("post_rst_rd",    32'(pipe.ex_rd),    32'd13);
    checkOutput("post_rst_ctrl",  32'(pipe.alu_ctrl), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
